// File: rtl/nvram_upload_pkg.sv
// nvram_pkg: FSM state codes, pad byte and latency-counter sizing shared by the NVRAM upload/restore blocks.
package nvram_pkg;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PAUSE = 3'd1;
  localparam logic [2:0] S_READY = 3'd2;
  localparam logic [2:0] S_REQ   = 3'd3;
  localparam logic [2:0] S_LAT   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [7:0] PAD_DEFAULT = 8'hFF;
  localparam int MAX_RD_LAT = 4;
  localparam int LAT_W = $clog2(MAX_RD_LAT + 1);
  typedef logic [7:0] nv_byte_t;
endpackage

// File: rtl/nvram_upload_if.sv
// nvram_upload_if: HPS ioctl upload channel, CPU pause handshake and arbitrated RAM read port.
interface nvram_upload_if import nvram_pkg::*; #(parameter int ADDR_W = 10);
  logic              ioctl_upload;
  logic              ioctl_rd;
  logic [ADDR_W-1:0] ioctl_addr;
  nv_byte_t          ioctl_din;
  logic              ioctl_wait;
  logic              cpu_pause;
  logic              pause_ack;
  logic              ram_req;
  logic              ram_gnt;
  logic [ADDR_W-1:0] ram_addr;
  nv_byte_t          ram_dout;
  modport master (
    output ioctl_upload, ioctl_rd, ioctl_addr, pause_ack, ram_gnt, ram_dout,
    input  ioctl_din, ioctl_wait, cpu_pause, ram_req, ram_addr
  );
  modport slave (
    input  ioctl_upload, ioctl_rd, ioctl_addr, pause_ack, ram_gnt, ram_dout,
    output ioctl_din, ioctl_wait, cpu_pause, ram_req, ram_addr
  );
endinterface

// File: rtl/nvram_upload_gnt_timer.sv
// nvram_gnt_timer: grant-wait timeout; cleared by load, counts while run, expire marks the GNT_TO-th waiting cycle.
module nvram_gnt_timer #(
  parameter int GNT_TO = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic run,
  output logic expire
);
  localparam int W = $clog2(GNT_TO + 1);
  logic [W-1:0] cnt;
  assign expire = run && cnt == W'(GNT_TO - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= '0;
    else if (run && !expire) cnt <= cnt + W'(1);
endmodule

// File: rtl/nvram_upload.sv
// nvram_upload: serves HPS upload reads from game work RAM while the CPU is paused.
// Optional NVRAM_UPLOAD_CKSUM_EN: a read at addr == SIZE returns the negated running byte sum.
module nvram_upload import nvram_pkg::*; #(
  parameter int          ADDR_W = 10,
  parameter int          SIZE   = 1024,
  parameter int          BASE   = 0,
  parameter int          RD_LAT = 1,
  parameter logic [7:0]  PAD    = PAD_DEFAULT,
  parameter int          GNT_TO = 255
) (
  input  logic           clk,
  input  logic           rst_n,
  nvram_upload_if.slave  bus,
  output logic           to_err
);
  logic [2:0]        state;
  logic              up_q, pend, expire, rise, abort, serve, oor, take;
  logic [ADDR_W-1:0] addr_q, a_sel;
  logic [LAT_W-1:0]  lat;
  nv_byte_t          oor_byte;
  always_comb begin
    rise  = bus.ioctl_upload && !up_q;
    abort = state != S_IDLE && !bus.ioctl_upload;
    serve = state == S_READY && (pend || bus.ioctl_rd);
    a_sel = pend ? addr_q : bus.ioctl_addr;
    oor   = int'(a_sel) >= SIZE;
    take  = state == S_LAT && lat == LAT_W'(1) && !abort;
  end
  nvram_gnt_timer #(.GNT_TO(GNT_TO)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (state == S_READY),
    .run    (state == S_REQ),
    .expire (expire)
  );
`ifdef NVRAM_UPLOAD_CKSUM_EN
  nv_byte_t sum;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sum <= '0;
    else if (state == S_IDLE && rise) sum <= '0;
    else if (take) sum <= sum + bus.ram_dout;
  assign oor_byte = int'(a_sel) == SIZE ? ~sum + 8'd1 : PAD;
`else
  assign oor_byte = PAD;
`endif
  // Upload falling aborts from any state; ioctl_din deliberately keeps its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      up_q          <= 1'b0;
      pend          <= 1'b0;
      addr_q        <= '0;
      lat           <= '0;
      to_err        <= 1'b0;
      bus.ioctl_din <= '0;
      bus.ioctl_wait <= 1'b0;
      bus.cpu_pause <= 1'b0;
      bus.ram_req   <= 1'b0;
      bus.ram_addr  <= '0;
    end else begin
      up_q <= bus.ioctl_upload;
      if (abort) begin
        state          <= S_IDLE;
        pend           <= 1'b0;
        bus.ioctl_wait <= 1'b0;
        bus.cpu_pause  <= 1'b0;
        bus.ram_req    <= 1'b0;
      end else begin
        case (state)
          S_IDLE:
            if (rise) begin
              state         <= S_PAUSE;
              bus.cpu_pause <= 1'b1;
              to_err        <= 1'b0;
            end
          S_PAUSE: begin
            if (bus.ioctl_rd && !pend) begin
              pend           <= 1'b1;
              addr_q         <= bus.ioctl_addr;
              bus.ioctl_wait <= 1'b1;
            end
            if (bus.pause_ack) state <= S_READY;
          end
          S_READY:
            if (serve) begin
              pend           <= 1'b0;
              bus.ioctl_wait <= 1'b1;
              if (oor) begin
                bus.ioctl_din <= oor_byte;
                state         <= S_DONE;
              end else begin
                bus.ram_addr <= ADDR_W'(BASE) + a_sel;
                bus.ram_req  <= 1'b1;
                state        <= S_REQ;
              end
            end
          S_REQ:
            if (bus.ram_gnt) begin
              bus.ram_req <= 1'b0;
              lat         <= LAT_W'(RD_LAT);
              state       <= S_LAT;
            end else if (expire) begin
              bus.ioctl_din <= PAD;
              bus.ram_req   <= 1'b0;
              to_err        <= 1'b1;
              state         <= S_DONE;
            end
          S_LAT:
            if (take) begin
              bus.ioctl_din <= bus.ram_dout;
              state         <= S_DONE;
            end else lat <= lat - LAT_W'(1);
          S_DONE: begin
            bus.ioctl_wait <= 1'b0;
            state          <= S_READY;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_nvram_upload.sv
// tb_nvram_upload: directed checks of the upload responder against a 2-cycle-latency RAM model.
module tb_nvram_upload;
  localparam int ADDR_W = 10;
  localparam int SIZE   = 512;
  localparam int BASE   = 16;
  localparam int RD_LAT = 2;
  localparam int GNT_TO = 20;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic to_err;
  int checks = 0;
  int failures = 0;
  logic [7:0] mem [1024];
  logic [7:0] p0, p1;
  nvram_upload_if #(.ADDR_W(ADDR_W)) bus ();
  nvram_upload #(
    .ADDR_W(ADDR_W), .SIZE(SIZE), .BASE(BASE), .RD_LAT(RD_LAT), .PAD(8'hFF), .GNT_TO(GNT_TO)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .to_err (to_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus.ram_gnt) p0 <= mem[bus.ram_addr];
    p1 <= p0;
  end
  assign bus.ram_dout = p1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // gdly: cycles of ram_req before the grant (-1 never grants); n is the cycle wait is seen low
  task automatic rd_cycle(input logic [9:0] a, input int gdly, output int n, output logic saw_req,
                          output logic [9:0] ra);
    int g;
    g = 0;
    saw_req = 1'b0;
    ra = '0;
    bus.ioctl_rd = 1'b1;
    bus.ioctl_addr = a;
    tick;
    bus.ioctl_rd = 1'b0;
    n = 1;
    while (bus.ioctl_wait && n < 100) begin
      if (bus.ram_req) begin
        if (!saw_req) ra = bus.ram_addr;
        saw_req = 1'b1;
        if (g == gdly) bus.ram_gnt = 1'b1;
        g++;
      end
      tick;
      bus.ram_gnt = 1'b0;
      n++;
    end
  endtask
  initial begin
    int n;
    logic sr;
    logic [9:0] ra;
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[BASE+5] = 8'hA7;
    for (int i = 0; i < 4; i++) mem[BASE+i] = 8'(i + 1);
    bus.ioctl_upload = 1'b0;
    bus.ioctl_rd = 1'b0;
    bus.ioctl_addr = '0;
    bus.pause_ack = 1'b0;
    bus.ram_gnt = 1'b0;
    #1 rst_n = 1'b0;
    tick;
    tick;
    check("rst_din", bus.ioctl_din, 0);
    check("rst_wait", bus.ioctl_wait, 0);
    check("rst_pause", bus.cpu_pause, 0);
    check("rst_req", bus.ram_req, 0);
    check("rst_addr", bus.ram_addr, 0);
    check("rst_toerr", to_err, 0);
    rst_n = 1'b1;
    tick;
    bus.ioctl_upload = 1'b1;
    tick;
    check("pause_on", bus.cpu_pause, 1);
    tick;
    tick;
    bus.pause_ack = 1'b1;
    tick;
    tick;
    tick;
    check("idle_req", bus.ram_req, 0);
    check("idle_wait", bus.ioctl_wait, 0);
    rd_cycle(10'd5, 1, n, sr, ra);
    check("rd5_turn", n, 6);
    check("rd5_req", sr, 1);
    check("rd5_addr", ra, BASE + 5);
    check("rd5_din", bus.ioctl_din, 8'hA7);
    check("rd5_pause", bus.cpu_pause, 1);
    rd_cycle(10'd5, 0, n, sr, ra);
    check("rd5_fast", n, RD_LAT + 3);
    rd_cycle(10'd100, 0, n, sr, ra);
    check("rd100_din", bus.ioctl_din, 8'(BASE + 100) ^ 8'h5A);
    rd_cycle(10'(SIZE + 3), 0, n, sr, ra);
    check("oor_turn", n, 2);
    check("oor_req", sr, 0);
    check("oor_din", bus.ioctl_din, 8'hFF);
    rd_cycle(10'd7, -1, n, sr, ra);
    check("to_turn", n, GNT_TO + 2);
    check("to_din", bus.ioctl_din, 8'hFF);
    check("to_err", to_err, 1);
    check("to_req", bus.ram_req, 0);
    bus.ioctl_upload = 1'b0;
    bus.pause_ack = 1'b0;
    tick;
    check("end_pause", bus.cpu_pause, 0);
    check("end_toerr", to_err, 1);
    bus.ioctl_upload = 1'b1;
    tick;
    check("restart_toerr", to_err, 0);
    check("restart_pause", bus.cpu_pause, 1);
    bus.ioctl_rd = 1'b1;
    bus.ioctl_addr = 10'd5;
    tick;
    bus.ioctl_rd = 1'b0;
    check("latch_wait", bus.ioctl_wait, 1);
    check("latch_noreq", bus.ram_req, 0);
    bus.pause_ack = 1'b1;
    tick;
    tick;
    check("latch_req", bus.ram_req, 1);
    check("latch_addr", bus.ram_addr, BASE + 5);
    bus.ram_gnt = 1'b1;
    tick;
    bus.ram_gnt = 1'b0;
    bus.ioctl_upload = 1'b0;
    tick;
    check("abort_wait", bus.ioctl_wait, 0);
    check("abort_req", bus.ram_req, 0);
    check("abort_pause", bus.cpu_pause, 0);
    tick;
    tick;
    tick;
    check("abort_din", bus.ioctl_din, 8'hFF);
    bus.ioctl_upload = 1'b1;
    tick;
    tick;
    for (int i = 0; i < 4; i++) begin
      rd_cycle(10'(i), 0, n, sr, ra);
      check("seq_din", bus.ioctl_din, i + 1);
    end
    rd_cycle(10'(SIZE), 0, n, sr, ra);
    check("size_req", sr, 0);
`ifdef NVRAM_UPLOAD_CKSUM_EN
    check("size_din", bus.ioctl_din, 8'hF6);
`else
    check("size_din", bus.ioctl_din, 8'hFF);
`endif
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_pause", bus.cpu_pause, 0);
    check("arst_din", bus.ioctl_din, 0);
    check("arst_wait", bus.ioctl_wait, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule

// File: doc/nvram_upload.md
Name: nvram_upload

Overview:
- Responder for the HPS ioctl upload channel, the read-back counterpart of the ROM/NVRAM download path.
- On HPS read requests, it pauses the game CPU, fetches bytes from game work RAM (hiscore/NVRAM region) through an arbitrated read port, and returns them on ioctl_din with a wait handshake.
- Sits between hps_io and the game RAM arbiter, in the clk domain.

Parameters:
- ADDR_W, 10, width of ioctl_addr and ram_addr used.
- SIZE, 1024, number of valid bytes; addresses >= SIZE are out of range.
- BASE, 0, RAM address of byte 0 of the image (ram_addr = BASE + ioctl_addr).
- RD_LAT, 1, cycles from granted ram_addr to valid ram_dout (1..4).
- PAD, 8'hFF, byte returned for out-of-range or timed-out reads.
- GNT_TO, 255, max cycles waiting for ram_gnt before abandoning a read.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ioctl_upload  in  1  HPS upload session active (level).
- ioctl_rd  in  1  single-cycle read strobe; ioctl_addr is valid with it.
- ioctl_addr  in  ADDR_W  byte address within the image.
- ioctl_din  out  8  returned byte.
- ioctl_wait  out  1  high while a read is outstanding.
- cpu_pause  out  1  request to halt the game CPU.
- pause_ack  in  1  CPU halted; RAM bus is free to arbitrate.
- ram_req  out  1  RAM read request (level, held until grant).
- ram_gnt  in  1  single-cycle grant; ram_addr is sampled in that cycle.
- ram_addr  out  ADDR_W  RAM address.
- ram_dout  in  8  RAM read data.
- to_err  out  1  sticky timeout flag; cleared at each upload start.

Behaviour:
- Reset values: ioctl_din=0, ioctl_wait=0, cpu_pause=0, ram_req=0, ram_addr=0, to_err=0, state IDLE.
- States: IDLE, PAUSE, READY, REQ, LAT, DONE.
- IDLE:
  - Rising edge of ioctl_upload -> PAUSE.
  - Set cpu_pause=1 and clear to_err.
- PAUSE:
  - Hold cpu_pause.
  - pause_ack=1 -> READY.
  - An ioctl_rd arriving here is latched (addr captured) and ioctl_wait is raised in the next cycle; it is served on entry to READY.
- READY, on ioctl_rd (or a latched rd):
  - Capture the address; ioctl_wait=1 from the next cycle.
  - If addr >= SIZE: ioctl_din=PAD, go to DONE; no RAM access.
  - Otherwise drive ram_addr=BASE+addr (mod 2^ADDR_W), ram_req=1, go to REQ.
- REQ:
  - On ram_gnt: drop ram_req next cycle, load the latency counter with RD_LAT, go to LAT.
  - Timeout counter increments each cycle. On reaching GNT_TO: ioctl_din=PAD, to_err=1, ram_req=0, go to DONE.
- LAT:
  - Count down. At zero, sample ram_dout into ioctl_din and go to DONE.
  - Grant-to-data latency is exactly RD_LAT cycles.
- DONE:
  - Drop ioctl_wait (one-cycle state), go to READY.
  - Minimum in-range turnaround: rd -> ioctl_wait low = RD_LAT+3 cycles with immediate grant.
- A new ioctl_rd while ioctl_wait=1 is a protocol violation; it is ignored and not queued.
- ioctl_upload falls in any state:
  - Abort any outstanding read; drop ram_req, ioctl_wait and cpu_pause; go to IDLE next cycle.
  - ioctl_din holds its last value.
- Async reset mid-session: all outputs return to reset values immediately; cpu_pause released.
- cpu_pause stays high through the whole session, including between reads.

Optional Feature:
- Macro: NVRAM_UPLOAD_CKSUM_EN.
- Defined:
  - An 8-bit running sum accumulates every byte returned from RAM in the session; it resets at session start.
  - A read at addr == SIZE returns the two's-complement of the sum (image plus checksum sums to 0) instead of PAD.
  - Reads at addr > SIZE still return PAD.
  - The sum is valid only for strictly sequential reads 0..SIZE-1; no ordering check is made.
- Undefined: addr == SIZE returns PAD; no accumulator is synthesised.

Decomposition:
- Shared package nvram_pkg:
  - state enum (IDLE..DONE), PAD default, the max-RD_LAT constant (4).
  - Latency-counter width derived from it.
- One natural sub-module: nvram_gnt_timer, the REQ-state timeout counter with load/expire outputs, reusable by the future download-restore writer.

Test Plan:
- Reset, then assert ioctl_upload with pause_ack tied high after 3 cycles -> cpu_pause=1 one cycle after the upload edge; READY reached; no ram_req until an ioctl_rd.
- RAM preloaded with RAM[BASE+5]=8'hA7, RD_LAT=2, grant in the cycle after req; ioctl_rd addr=5 -> ram_addr=BASE+5, ioctl_din=8'hA7, ioctl_wait high for exactly 5 cycles.
- ioctl_rd addr=SIZE+3 -> no ram_req; ioctl_din=8'hFF; ioctl_wait low 2 cycles after rd.
- ram_gnt held low -> after GNT_TO cycles ioctl_din=8'hFF, to_err=1, ram_req=0. A following upload restart clears to_err.
- ioctl_upload dropped while in LAT -> ioctl_wait, ram_req and cpu_pause all 0 next cycle; state IDLE. A late ram_dout does not change ioctl_din.
- With NVRAM_UPLOAD_CKSUM_EN, SIZE=4, bytes 01,02,03,04 read in order, then addr=4 -> ioctl_din=8'hF6.
